// File: rtl/cargador_pkg.sv
// Shared definitions for the serial operand loader: FSM encoding and counter sizing.
package cargador_pkg;

  typedef enum logic [1:0] {
    CARGA     = 2'd0,
    EVAL      = 2'd1,
    RESULTADO = 2'd2
  } state_t;

  // Beat counter width: max(1, clog2(k)).
  function automatic int cnt_w(input int k);
    return (k <= 1) ? 1 : (($clog2(k) < 1) ? 1 : $clog2(k));
  endfunction

endpackage

// File: rtl/registro_serial.sv
// K-bit shift-in register, new bit enters at index 0 so the first bit ends up at K-1.
module registro_serial #(
  parameter int K = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         en,
  input  logic         din,
  output logic [K-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   q <= '0;
    else if (clear) q <= '0;
    else if (en)    q <= {q[K-2:0], din};
  end

endmodule

// File: rtl/cargador_serial.sv
// Serial-in operand stage: loads A/B MSB first, samples network Z once, holds it under valid/ready.
module cargador_serial
  import cargador_pkg::*;
#(
  parameter int K = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         a_bit,
  input  logic         b_bit,
  output logic [K-1:0] A,
  output logic [K-1:0] B,
  output logic         ops_valid,
  input  logic         z_in,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         z_out
);

  localparam int CW = cnt_w(K);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          accept, last;

  assign accept = in_valid & in_ready;
  assign last   = (cnt == CW'(K-1));

  registro_serial #(.K(K)) u_reg_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .en(accept), .din(a_bit), .q(A)
  );

  registro_serial #(.K(K)) u_reg_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .en(accept), .din(b_bit), .q(B)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= CARGA;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      CARGA:     if (accept && last) state_nx = EVAL;
      EVAL:      state_nx = RESULTADO;
      RESULTADO: if (res_ready) state_nx = CARGA;
      default:   state_nx = CARGA;
    endcase
    if (clear) state_nx = CARGA;
  end

  always_comb begin
    in_ready  = 1'b0;
    ops_valid = 1'b0;
    res_valid = 1'b0;
    case (state)
      CARGA:     in_ready = 1'b1;
      EVAL:      ops_valid = 1'b1;
      RESULTADO: begin
        ops_valid = 1'b1;
        res_valid = 1'b1;
      end
      default:   in_ready = 1'b0;
    endcase
  end

  // Counter stops at K-1 and folds back to 0 on the final beat, so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (accept) cnt <= last ? '0 : cnt + CW'(1);
  end

  // Z is sampled only at the end of EVAL; A/B have been stable for the whole cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             z_out <= 1'b0;
    else if (clear)           z_out <= 1'b0;
    else if (state == EVAL)   z_out <= z_in;
  end

endmodule

// File: tb/tb_cargador_serial.sv
// Bench for cargador_serial: vector table, directed corner sequences, random run vs. beat-count model.
module tb_cargador_serial;

  localparam int K    = 5;
  localparam int MASK = (1 << K) - 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         a_bit = 1'b0;
  logic         b_bit = 1'b0;
  logic [K-1:0] A, B;
  logic         ops_valid;
  logic         z_in = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic         z_out;

  cargador_serial #(.K(K)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .a_bit(a_bit), .b_bit(b_bit),
    .A(A), .B(B), .ops_valid(ops_valid), .z_in(z_in),
    .res_valid(res_valid), .res_ready(res_ready), .z_out(z_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference: operands as integers, how many beats are loaded, whether Z was taken.
  int m_a = 0, m_b = 0, m_n = 0, m_z = 0;
  bit m_evald = 1'b0;

  task automatic model_reset();
    m_a = 0; m_b = 0; m_n = 0; m_z = 0; m_evald = 1'b0;
  endtask

  task automatic model_update();
    if (clear) model_reset();
    else if (m_n < K) begin
      if (in_valid) begin
        m_a = ((m_a << 1) | int'(a_bit)) & MASK;
        m_b = ((m_b << 1) | int'(b_bit)) & MASK;
        m_n++;
      end
    end else if (!m_evald) begin
      m_z = int'(z_in);
      m_evald = 1'b1;
    end else if (res_ready) begin
      m_n = 0;
      m_evald = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".in_ready"},  int'(in_ready),  (m_n < K) ? 1 : 0);
    chk({tag, ".ops_valid"}, int'(ops_valid), (m_n == K) ? 1 : 0);
    chk({tag, ".res_valid"}, int'(res_valid), (m_n == K && m_evald) ? 1 : 0);
    chk({tag, ".z_out"},     int'(z_out),     m_z);
    chk({tag, ".A"},         int'(A),         m_a);
    chk({tag, ".B"},         int'(B),         m_b);
    chk({tag, ".cnt"},       int'(dut.cnt),   (m_n < K) ? m_n : 0);
  endtask

  task automatic drive(input logic iv, input logic a, input logic b, input logic z,
                       input logic rr, input logic cl);
    in_valid = iv; a_bit = a; b_bit = b; z_in = z; res_ready = rr; clear = cl;
  endtask

  // Inputs are set at the falling edge; outputs are checked at the next falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
  endtask

  task automatic load(input logic [K-1:0] av, input logic [K-1:0] bv, input logic z);
    for (int i = K-1; i >= 0; i--) begin
      drive(1'b1, av[i], bv[i], z, 1'b0, 1'b0);
      step();
      check_model("load");
    end
  endtask

  typedef struct {
    logic iv, a, b, z, rr;
    logic ir, ov, rv, zo;
    logic [K-1:0] ea, eb;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int t0, t1, t2, rise1, rise2;
    logic prev;
    logic [K-1:0] va, vb;

    tbl[0] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 5'b00001, 5'b00000};
    tbl[1] = '{1'b1,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 5'b00010, 5'b00001};
    tbl[2] = '{1'b1,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 5'b00101, 5'b00011};
    tbl[3] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 5'b01011, 5'b00110};
    tbl[4] = '{1'b1,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0, 5'b10110, 5'b01101};
    tbl[5] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b1, 5'b10110, 5'b01101};
    tbl[6] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1, 5'b10110, 5'b01101};
    tbl[7] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1, 5'b01101, 5'b11011};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.in_ready", int'(in_ready), 1);
    chk("rst.ops_valid", int'(ops_valid), 0);
    chk("rst.res_valid", int'(res_valid), 0);
    chk("rst.z_out", int'(z_out), 0);
    chk("rst.A", int'(A), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Scenario 1 and handshake from the vector table
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].iv, tbl[i].a, tbl[i].b, tbl[i].z, tbl[i].rr, 1'b0);
      step();
      chk($sformatf("tbl%0d.in_ready", i),  int'(in_ready),  int'(tbl[i].ir));
      chk($sformatf("tbl%0d.ops_valid", i), int'(ops_valid), int'(tbl[i].ov));
      chk($sformatf("tbl%0d.res_valid", i), int'(res_valid), int'(tbl[i].rv));
      chk($sformatf("tbl%0d.z_out", i),     int'(z_out),     int'(tbl[i].zo));
      chk($sformatf("tbl%0d.A", i),         int'(A),         int'(tbl[i].ea));
      chk($sformatf("tbl%0d.B", i),         int'(B),         int'(tbl[i].eb));
    end

    // Scenario 2: two idle cycles between beats 2 and 3
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step(); check_model("s2clr");
    va = 5'b10110; vb = 5'b01101;
    t0 = cyc;
    for (int i = K-1; i >= 0; i--) begin
      drive(1'b1, va[i], vb[i], 1'b1, 1'b0, 1'b0); step(); check_model("s2");
      if (i == K-2) begin
        for (int j = 0; j < 2; j++) begin
          drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); step(); check_model("s2idle");
          chk("s2.cnt_hold", int'(dut.cnt), 2);
        end
      end
    end
    t1 = -1;
    for (int i = 0; i < 10 && t1 < 0; i++) begin
      if (res_valid) t1 = cyc;
      else begin drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step(); check_model("s2wait"); end
    end
    chk("s2.latency", t1 - t0, K + 1 + 2);
    chk("s2.A", int'(A), 22);
    chk("s2.B", int'(B), 13);

    // Scenario 3: result stall with z_in toggling
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, logic'(i % 2 == 0 ? 1'b0 : 1'b1), 1'b0, 1'b0);
      step(); check_model("s3stall");
      chk("s3.z_hold", int'(z_out), 1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); step(); check_model("s3rel");
    chk("s3.in_ready", int'(in_ready), 1);

    // Scenario 4: clear after 3 beats, with in_valid also high
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); step(); check_model("s4pre");
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); step(); check_model("s4clr");
    chk("s4.A_zero", int'(A), 0);
    chk("s4.cnt_zero", int'(dut.cnt), 0);
    load(5'b11001, 5'b00111, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step(); check_model("s4eval");
    chk("s4.res_valid", int'(res_valid), 1);

    // Scenario 5: asynchronous reset while holding a result
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); model_update(); cyc++;
    #2 reset_n = 1'b0;
    #1;
    chk("s5.res_valid", int'(res_valid), 0);
    chk("s5.z_out", int'(z_out), 0);
    chk("s5.in_ready", int'(in_ready), 1);
    chk("s5.A", int'(A), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(); check_model("s5post");

    // Scenario 6: back-to-back comparisons with res_ready held high
    rise1 = -1; rise2 = -1; prev = res_valid;
    for (int i = 0; i < 40 && rise2 < 0; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b1, 1'b0);
      step(); check_model("s6");
      if (res_valid && !prev) begin
        if (rise1 < 0) rise1 = cyc; else rise2 = cyc;
      end
      prev = res_valid;
    end
    chk("s6.seen_two", (rise1 >= 0 && rise2 >= 0) ? 1 : 0, 1);
    chk("s6.gap", rise2 - rise1, K + 2);

    // Random traffic against the model
    t2 = 0;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 29) == 0));
      step(); check_model("rnd");
      if (res_valid) t2++;
    end
    chk("rnd.saw_results", (t2 > 0) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
